// File: rtl/trace_pkg.sv
// Shared constants and FSM state encoding for the trace requester.
package trace_pkg;

  localparam int DATA_W = 256;
  localparam int SEL_W  = 9;
  localparam int IDX_W  = $clog2(DATA_W);

  localparam logic [7:0] REQ_GET  = 8'h06;
  localparam logic [7:0] REQ_STAT = 8'h86;
  localparam logic [7:0] REQ_IDLE = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_ISSUE       = 3'd1,
    ST_SAMPLE      = 3'd2,
    ST_STAT_ISSUE  = 3'd3,
    ST_STAT_SAMPLE = 3'd4,
    ST_DONE        = 3'd5
  } state_t;

endpackage

// File: rtl/trace_requester.sv
// Reads a window of the responder's trace vector one bit per GET request,
// then closes the run with a STATUS request and checks the returned index.
module trace_requester
  import trace_pkg::*;
(
  input  logic              clk,
  input  logic              reset_L,
  input  logic              start,
  input  logic [SEL_W-1:0]  first_sel,
  input  logic [SEL_W-1:0]  count,
  output logic [7:0]        bRequest,
  output logic [SEL_W-1:0]  select,
  input  logic              q,
  input  logic [15:0]       parameter_Block16,
  output logic [DATA_W-1:0] capture,
  output logic [15:0]       status_word,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [SEL_W:0]   DATA_W_X = (SEL_W+1)'(DATA_W);
  localparam logic [SEL_W-1:0] ONE      = SEL_W'(1);

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    idx_q, idx_d;
  logic [SEL_W-1:0]    rem_q, rem_d;
  logic [DATA_W-1:0]   capture_q, capture_d;
  logic [15:0]         status_q, status_d;
  logic                error_q, error_d;
  logic [SEL_W:0]      end_sum;
  logic                range_err;

  // Window end computed one bit wider so first_sel+count cannot overflow.
  assign end_sum   = {1'b0, first_sel} + {1'b0, count};
  assign range_err = (end_sum > DATA_W_X) || ({1'b0, count} > DATA_W_X);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rem_d     = rem_q;
    capture_d = capture_q;
    status_d  = status_q;
    error_d   = error_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d     = first_sel;
          rem_d     = count;
          capture_d = '0;
          status_d  = '0;
          error_d   = 1'b0;
          if (range_err) begin
            error_d = 1'b1;
            state_d = ST_DONE;
          end else if (count == '0) begin
            state_d = ST_STAT_ISSUE;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: state_d = ST_SAMPLE;
      ST_SAMPLE: begin
        capture_d[idx_q[IDX_W-1:0]] = q;
        rem_d = rem_q - ONE;
        // idx stays on the last bit so the STATUS request reports it.
        if (rem_q != ONE) begin
          idx_d   = idx_q + ONE;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_STAT_ISSUE;
        end
      end
      ST_STAT_ISSUE: state_d = ST_STAT_SAMPLE;
      ST_STAT_SAMPLE: begin
        status_d = parameter_Block16;
        if (parameter_Block16[SEL_W-1:0] != idx_q) error_d = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      rem_q     <= '0;
      capture_q <= '0;
      status_q  <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rem_q     <= rem_d;
      capture_q <= capture_d;
      status_q  <= status_d;
      error_q   <= error_d;
    end
  end

  // Bus outputs decode directly from state so an async reset clears them at once.
  always_comb begin
    bRequest = REQ_IDLE;
    case (state_q)
      ST_ISSUE, ST_SAMPLE:           bRequest = REQ_GET;
      ST_STAT_ISSUE, ST_STAT_SAMPLE: bRequest = REQ_STAT;
      default:                       bRequest = REQ_IDLE;
    endcase
  end

  assign select      = idx_q;
  assign capture     = capture_q;
  assign status_word = status_q;
  assign error       = error_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);

endmodule
